mul_sequencer: RTL and testbench

- Iterative shift-add multiplier controller for the ALU multiply class (MUL, SMULL, UMULL).
- Sequences a 32x32 product over a fixed number of cycles, so the datapath no longer carries a combinational 64-bit multiplier.
- Sits beside the ALU. The control unit starts it and stalls on busy, then consumes result_lo/result_hi/flags when done pulses.

---
 rtl/mul_sequencer.sv | 114 +++++++++++
 tb/tb_mul_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative shift-add 32x32 multiplier sequencer for MUL/SMULL/UMULL
module mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mul_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_SMULL = 2'b01;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   mplr;
    logic               neg;

    logic               is_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] full;
    logic [2*WIDTH-1:0] prod;
    logic               flag_n;
    logic               flag_z;

    assign is_signed = (mul_op == OP_SMULL);
    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct as unsigned.
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // Upper half plus carry; the shift moves the carry back into acc_hi's MSB.
    assign sum  = {1'b0, acc_hi} + (mplr[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});
    assign full = {acc_hi, mplr};
    assign prod = neg ? -full : full;

    always_comb begin
        flag_n = prod[2*WIDTH-1];
        flag_z = (prod == '0);
        if (op_q == OP_MUL) begin
            flag_n = prod[WIDTH-1];
            flag_z = (prod[WIDTH-1:0] == '0);
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_q      <= 2'b00;
            cnt       <= '0;
            mcand     <= '0;
            acc_hi    <= '0;
            mplr      <= '0;
            neg       <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            flags     <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= mul_op;
                        mcand  <= is_signed ? abs_a : a;
                        mplr   <= is_signed ? abs_b : b;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_hi <= '0;
                        cnt    <= '0;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_hi <= sum[WIDTH:1];
                    mplr   <= {sum[0], mplr[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_lo <= prod[WIDTH-1:0];
                    result_hi <= prod[2*WIDTH-1:WIDTH];
                    flags     <= {flag_n, flag_z, 2'b00};
                    state     <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - directed self-checking bench for mul_sequencer
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mul_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic [3:0]  flags;

    int total = 0;
    int bad   = 0;

    mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mul_op    (mul_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Called at a negedge; drives start for one edge then tracks the op until busy drops.
    // inject re-asserts start with other operands at cycles 5, 33 and 34 (the done cycle).
    task automatic run_op(input logic [1:0] op, input logic [31:0] va, input logic [31:0] vb,
                          input bit inject, output int lat, output int bcnt, output int pulses);
        int cyc;
        start  = 1'b1;
        mul_op = op;
        a      = va;
        b      = vb;
        @(negedge clk);
        a = $urandom;
        b = $urandom;
        mul_op = 2'($urandom);
        cyc = 1; lat = 0; bcnt = 0; pulses = 0;
        while (cyc < 80) begin
            start = 1'b0;
            if (!busy) break;
            bcnt++;
            if (done) begin
                pulses++;
                if (lat == 0) lat = cyc;
            end
            if (inject && (cyc == 5 || cyc == 33 || cyc == 34)) begin
                start  = 1'b1;
                mul_op = 2'b11;
                a      = 32'h0000_0007;
                b      = 32'h0000_0009;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 80) begin
            total++; bad++;
            $display("FAIL timeout: busy still high after %0d cycles (required <= 35)", cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; mul_op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (result_lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", result_lo); end
        total++; if (result_hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", result_hi); end
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", flags); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_umull_max();
        int lat, bc, np;
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bc, np);
        total++; if (lat !== 34) begin bad++; $display("FAIL umull_max_latency: got %0d want 34", lat); end
        total++; if (np !== 1) begin bad++; $display("FAIL umull_max_pulses: got %0d want 1", np); end
        total++; if (result_hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL umull_max_hi: got %h want fffffffe", result_hi); end
        total++; if (result_lo !== 32'h0000_0001) begin bad++; $display("FAIL umull_max_lo: got %h want 00000001", result_lo); end
        total++; if (flags !== 4'b1000) begin bad++; $display("FAIL umull_max_flags: got %b want 1000", flags); end
    endtask

    task automatic test_smull();
        int lat, bc, np;
        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, lat, bc, np);
        total++; if (lat !== 34) begin bad++; $display("FAIL smull_neg_latency: got %0d want 34", lat); end
        total++; if (result_hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL smull_neg_hi: got %h want ffffffff", result_hi); end
        total++; if (result_lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL smull_neg_lo: got %h want fffffffe", result_lo); end
        total++; if (flags !== 4'b1000) begin bad++; $display("FAIL smull_neg_flags: got %b want 1000", flags); end
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, bc, np);
        total++; if (result_hi !== 32'h4000_0000) begin bad++; $display("FAIL smull_min_hi: got %h want 40000000", result_hi); end
        total++; if (result_lo !== 32'h0000_0000) begin bad++; $display("FAIL smull_min_lo: got %h want 00000000", result_lo); end
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL smull_min_flags: got %b want 0000", flags); end
    endtask

    task automatic test_mul_low_word();
        int lat, bc, np;
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b0, lat, bc, np);
        total++; if (result_lo !== 32'h0000_0000) begin bad++; $display("FAIL mul_lo: got %h want 00000000", result_lo); end
        total++; if (result_hi !== 32'h0000_0001) begin bad++; $display("FAIL mul_hi: got %h want 00000001", result_hi); end
        total++; if (flags !== 4'b0100) begin bad++; $display("FAIL mul_flags: got %b want 0100", flags); end
        // op 10 behaves as UMULL: sign bits must not be stripped
        run_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, lat, bc, np);
        total++; if (result_hi !== 32'h0000_0001) begin bad++; $display("FAIL op10_hi: got %h want 00000001", result_hi); end
        total++; if (result_lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL op10_lo: got %h want fffffffe", result_lo); end
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL op10_flags: got %b want 0000", flags); end
    endtask

    task automatic test_zero_operand();
        int lat, bc, np;
        run_op(2'b11, 32'h0000_0000, 32'h1234_5678, 1'b0, lat, bc, np);
        total++; if (lat !== 34) begin bad++; $display("FAIL zero_latency: got %0d want 34", lat); end
        total++; if (bc !== 34) begin bad++; $display("FAIL zero_busy_cycles: got %0d want 34", bc); end
        total++; if (result_hi !== 32'h0) begin bad++; $display("FAIL zero_hi: got %h want 0", result_hi); end
        total++; if (result_lo !== 32'h0) begin bad++; $display("FAIL zero_lo: got %h want 0", result_lo); end
        total++; if (flags !== 4'b0100) begin bad++; $display("FAIL zero_flags: got %b want 0100", flags); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, np;
        run_op(2'b11, 32'h0000_1234, 32'h0000_0010, 1'b1, lat, bc, np);
        total++; if (np !== 1) begin bad++; $display("FAIL ignore_pulses: got %0d want 1", np); end
        total++; if (lat !== 34) begin bad++; $display("FAIL ignore_latency: got %0d want 34", lat); end
        total++; if (result_lo !== 32'h0001_2340) begin bad++; $display("FAIL ignore_lo: got %h want 00012340", result_lo); end
        total++; if (result_hi !== 32'h0) begin bad++; $display("FAIL ignore_hi: got %h want 0", result_hi); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_idle_after: got busy=%b want 0", busy); end
        run_op(2'b11, 32'h0000_0006, 32'h0000_0007, 1'b0, lat, bc, np);
        total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency: got %0d want 34", lat); end
        total++; if (result_lo !== 32'h0000_002A) begin bad++; $display("FAIL b2b_lo: got %h want 0000002a", result_lo); end
    endtask

    task automatic test_reset_abort();
        int lat, bc, np, seen;
        start = 1'b1; mul_op = 2'b11; a = 32'hDEAD_BEEF; b = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (result_lo !== 32'h0) begin bad++; $display("FAIL abort_lo: got %h want 0", result_lo); end
        total++; if (result_hi !== 32'h0) begin bad++; $display("FAIL abort_hi: got %h want 0", result_hi); end
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL abort_flags: got %b want 0000", flags); end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_done_pulse: got %0d pulses want 0", seen); end
        run_op(2'b11, 32'h0000_0003, 32'h0000_0005, 1'b0, lat, bc, np);
        total++; if (result_lo !== 32'h0000_000F) begin bad++; $display("FAIL post_reset_lo: got %h want 0000000f", result_lo); end
        total++; if (result_hi !== 32'h0) begin bad++; $display("FAIL post_reset_hi: got %h want 0", result_hi); end
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL post_reset_flags: got %b want 0000", flags); end
    endtask

    initial begin
        test_reset();
        test_umull_max();
        test_smull();
        test_mul_low_word();
        test_zero_operand();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
